horner_sequencer: RTL and testbench
===================================

# horner_sequencer

Sequencer for the ADC correction datapath: the shared floating-point multiplier, adder and accumulator that evaluate the correction polynomial by Horner's rule. It accepts one sample request, clears the accumulator, then issues ORDER+1 multiply-add steps, stepping the coefficient select from ORDER down to 0. It signals result-valid and flags overrun and stalled-datapath errors. It sits between the sample-ready input and the multiplier/adder/accumulator chain, in place of a free-running controller.

## Interface
- ORDER, 9: polynomial degree; ORDER+1 steps per sample.
- SEL_W, 4: coeff_sel width; ORDER < 2^SEL_W.
- TIMEOUT, 63: maximum cycles spent in WAIT before aborting; ≥ 2.

- clk  in  1  system clock, rising edge.
- GlobalReset  in  1  asynchronous, active-low reset.
- srdyi  in  1  new sample valid; accepted only when busy=0.
- add_done_i  in  1  adder result valid (adder srdyo), one-cycle pulse.
- clr_err_i  in  1  clears sticky error flags.
- x_load  out  1  capture the input sample into the multiplier x register.
- sum_rst  out  1  clear the accumulator to 0.
- mul_srdy_o  out  1  launch one multiply-add step.
- sum_en  out  1  accumulator captures the adder result.
- coeff_sel  out  SEL_W  coefficient index for the current step.
- busy  out  1  evaluation in progress.
- srdyo  out  1  final result valid in the accumulator, one-cycle pulse.
- overrun_err  out  1  sticky; srdyi arrived while busy.
- timeout_err  out  1  sticky; the datapath stalled.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE. Reset forces IDLE.
- **IDLE:** on srdyi=1 go to LOAD and load coeff_sel=ORDER.
- **LOAD (1 cycle):**
  - Outputs: x_load=1, sum_rst=1.
  - Clears the timeout counter.
  - Next state: ISSUE.
- **ISSUE (1 cycle):**
  - Outputs: mul_srdy_o=1.
  - Clears the timeout counter.
  - Next state: WAIT.
- **WAIT:**
  - Timeout counter increments each cycle.
  - On add_done_i: sum_en=1 (combinational, WAIT & add_done_i).
  - If coeff_sel==0, go to DONE.
  - Otherwise decrement coeff_sel and go to ISSUE.
- **WAIT timeout:**
  - Trigger: counter reaches TIMEOUT-1 while add_done_i=0.
  - Go to IDLE and set timeout_err.
  - No srdyo is produced and the accumulator is left as is.
- **DONE (1 cycle):**
  - Outputs: srdyo=1.
  - On srdyi=1 go to LOAD (back-to-back sample), otherwise go to IDLE.
- **Output decode:**
  - busy=1 in LOAD, ISSUE and WAIT; busy=0 in IDLE and DONE.
  - All outputs except sum_en are Moore decodes of the state register.
- **Error flags:**
  - overrun_err is set by srdyi=1 while busy=1. The offending sample is dropped and the evaluation in progress continues unaffected.
  - If clr_err_i and an error event occur in the same cycle, set wins.
- **Ignored inputs:** add_done_i outside WAIT is ignored and does not count as an error.
- **Arithmetic:** first step runs with accumulator 0, giving c_ORDER; each later step computes acc = x·acc + c_sel.

## Timing
- Reset values:
  - State IDLE, coeff_sel=0, timeout counter 0.
  - All 1-bit outputs 0, including both error flags.
- Reset asserted mid-evaluation aborts immediately with no srdyo.
- L = cycles from mul_srdy_o high to add_done_i high, with L ≥ 1.
- Each step occupies L+1 cycles: ISSUE, then L cycles of WAIT.
- Latency, with srdyi sampled in cycle 0:
  - LOAD in cycle 1, first ISSUE in cycle 2.
  - srdyo in cycle 2+(ORDER+1)(L+1).
  - For ORDER=9, L=3: srdyo in cycle 42.
- Throughput: a new sample can be accepted in the DONE cycle, giving 2+(ORDER+1)(L+1) cycles per sample.
- coeff_sel is stable from LOAD/ISSUE through the add_done_i cycle of its step.
- Timeout boundary:
  - Abort when add_done_i is absent for TIMEOUT consecutive WAIT cycles.
  - add_done_i on the final allowed cycle is accepted normally.

## Test plan
- ORDER=9, L=3, single srdyi pulse at cycle 0:
  - coeff_sel steps 9,8,…,0.
  - Exactly 10 mul_srdy_o and 10 sum_en pulses.
  - srdyo only in cycle 42; busy high in cycles 1–41.
- Back-to-back samples: srdyi held high, L=1:
  - Second LOAD immediately follows DONE.
  - srdyo pulses every 22 cycles.
  - overrun_err is set, because srdyi stays high while busy.
- srdyi pulsed during WAIT of step 5:
  - overrun_err=1; the evaluation completes unchanged.
  - clr_err_i clears the flag next cycle; clr_err_i together with a new srdyi-while-busy keeps it at 1.
- Adder never responds:
  - After 63 WAIT cycles: state IDLE, timeout_err=1, no srdyo.
  - Repeat with add_done_i on the 63rd WAIT cycle: normal progression, timeout_err stays 0.
- GlobalReset pulsed low mid-evaluation at coeff_sel=4:
  - All outputs 0 asynchronously, no srdyo.
  - After release, a new srdyi completes normally.
- add_done_i pulses in IDLE and in ISSUE: no state change and no sum_en.

Source files
------------

// File: rtl/horner_sequencer.sv
// horner_sequencer
// ----------------
// Control sequencer for the ADC correction datapath. A shared multiplier,
// adder and accumulator evaluate the correction polynomial by Horner's rule.
// For each accepted sample this block clears the accumulator and then issues
// ORDER+1 multiply-add steps. The coefficient select counts down from ORDER
// to 0. It pulses srdyo when the result is ready and keeps sticky flags for
// overrun and stalled-datapath errors.
//
// Ports
//   clk          system clock, rising edge
//   GlobalReset  asynchronous reset, active low
//   srdyi        new sample valid (accepted only while busy is low)
//   add_done_i   adder result valid, one-cycle pulse
//   clr_err_i    clears the sticky error flags
//   x_load       capture the input sample into the multiplier x register
//   sum_rst      clear the accumulator to 0
//   mul_srdy_o   launch one multiply-add step
//   sum_en       accumulator captures the adder result (WAIT & add_done_i)
//   coeff_sel    coefficient index for the current step
//   busy         evaluation in progress (LOAD, ISSUE, WAIT)
//   srdyo        final result valid in the accumulator, one-cycle pulse
//   overrun_err  sticky: srdyi arrived while busy
//   timeout_err  sticky: adder did not answer within TIMEOUT WAIT cycles

module horner_sequencer #(
  parameter int ORDER   = 9,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             srdyi,
  input  logic             add_done_i,
  input  logic             clr_err_i,
  output logic             x_load,
  output logic             sum_rst,
  output logic             mul_srdy_o,
  output logic             sum_en,
  output logic [SEL_W-1:0] coeff_sel,
  output logic             busy,
  output logic             srdyo,
  output logic             overrun_err,
  output logic             timeout_err
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_load_q, x_load_d;
  logic             sum_rst_q, sum_rst_d;
  logic             mul_srdy_q, mul_srdy_d;
  logic             busy_q, busy_d;
  logic             srdyo_q, srdyo_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             timeout_evt;
  logic             overrun_evt;

  // Next-state logic. The coefficient select is loaded with ORDER when a
  // sample is accepted. It is decremented only when the adder answers, so it
  // holds steady from ISSUE through the add_done_i cycle of its step.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    timeout_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (srdyi) begin
          state_d = ST_LOAD;
          sel_d   = SEL_W'(ORDER);
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (add_done_i) begin
          if (sel_q == '0) begin
            state_d = ST_DONE;
          end else begin
            sel_d   = sel_q - 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th silent WAIT cycle, so abort. The
          // accumulator keeps whatever it holds and no srdyo is produced.
          state_d     = ST_IDLE;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end
      end
      ST_DONE: begin
        // busy is low in DONE, so a new sample can start back-to-back.
        if (srdyi) begin
          state_d = ST_LOAD;
          sel_d   = SEL_W'(ORDER);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The Moore outputs are decoded from the next state and then registered.
  // Each one is then a clean flop that tracks the state register exactly.
  // An error event has priority over a clear that arrives in the same cycle.
  always_comb begin
    x_load_d    = (state_d == ST_LOAD);
    sum_rst_d   = (state_d == ST_LOAD);
    mul_srdy_d  = (state_d == ST_ISSUE);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    srdyo_d     = (state_d == ST_DONE);
    overrun_evt = srdyi && busy_q;
    overrun_d   = overrun_evt || (overrun_q && !clr_err_i);
    timeout_d   = timeout_evt || (timeout_q && !clr_err_i);
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      x_load_q   <= 1'b0;
      sum_rst_q  <= 1'b0;
      mul_srdy_q <= 1'b0;
      busy_q     <= 1'b0;
      srdyo_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      x_load_q   <= x_load_d;
      sum_rst_q  <= sum_rst_d;
      mul_srdy_q <= mul_srdy_d;
      busy_q     <= busy_d;
      srdyo_q    <= srdyo_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  // sum_en must land in the same cycle as the adder pulse, so it is the
  // only output that is not registered.
  assign sum_en      = (state_q == ST_WAIT) && add_done_i;
  assign x_load      = x_load_q;
  assign sum_rst     = sum_rst_q;
  assign mul_srdy_o  = mul_srdy_q;
  assign coeff_sel   = sel_q;
  assign busy        = busy_q;
  assign srdyo       = srdyo_q;
  assign overrun_err = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// tb_horner_sequencer
// -------------------
// Drives horner_sequencer with a modelled adder that answers mul_srdy_o a
// set number of cycles later. A bench-side accumulator model is fed by the
// DUT control strobes. Each final result is compared with a polynomial
// computed directly as sum(c_i * x^i), and event timing is compared with the
// closed-form latency 2+(ORDER+1)(L+1).

module tb_horner_sequencer;

  localparam int ORDER   = 9;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 63;

  logic             clk = 1'b0;
  logic             GlobalReset;
  logic             srdyi;
  logic             add_done_i;
  logic             clr_err_i;
  logic             x_load;
  logic             sum_rst;
  logic             mul_srdy_o;
  logic             sum_en;
  logic [SEL_W-1:0] coeff_sel;
  logic             busy;
  logic             srdyo;
  logic             overrun_err;
  logic             timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  horner_sequencer #(.ORDER(ORDER), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .srdyi       (srdyi),
    .add_done_i  (add_done_i),
    .clr_err_i   (clr_err_i),
    .x_load      (x_load),
    .sum_rst     (sum_rst),
    .mul_srdy_o  (mul_srdy_o),
    .sum_en      (sum_en),
    .coeff_sel   (coeff_sel),
    .busy        (busy),
    .srdyo       (srdyo),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: answers each mul_srdy_o exactly resp_lat cycles later.
  // The directed steps can also inject stray pulses through manual_pulse.
  int   resp_lat     = 3;
  bit   resp_en      = 1'b1;
  int   resp_cnt     = 0;
  logic resp_pulse   = 1'b0;
  logic manual_pulse = 1'b0;
  assign add_done_i = resp_pulse | manual_pulse;

  always begin
    @(posedge clk);
    #1;
    resp_pulse = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_pulse = 1'b1;
    end
    if (mul_srdy_o && resp_en) resp_cnt = resp_lat;
  end

  // Datapath model plus event counters, sampled mid-cycle.
  logic [31:0]      coef [0:ORDER];
  logic [31:0]      x_in  = '0;
  logic [31:0]      x_reg = '0;
  logic [31:0]      acc   = '0;
  int unsigned      mul_cnt   = 0;
  int unsigned      sum_cnt   = 0;
  int unsigned      busy_cnt  = 0;
  int unsigned      srdyo_cnt = 0;
  logic [SEL_W-1:0] coeff_q [$];
  logic [31:0]      result_q [$];

  always @(negedge clk) begin
    if (mul_srdy_o) begin
      mul_cnt++;
      coeff_q.push_back(coeff_sel);
    end
    if (sum_en) begin
      sum_cnt++;
      acc = x_reg * acc + coef[coeff_sel];
    end
    if (busy) busy_cnt++;
    if (srdyo) begin
      srdyo_cnt++;
      result_q.push_back(acc);
    end
    if (x_load) x_reg = x_in;
    if (sum_rst) acc = '0;
  end

  // Reference polynomial as an explicit power sum (mod 2^32).
  function automatic logic [31:0] polyRef(input logic [31:0] x);
    logic [31:0] s = '0;
    logic [31:0] p = 32'd1;
    for (int i = 0; i <= ORDER; i++) begin
      s = s + coef[i] * p;
      p = p * x;
    end
    return s;
  endfunction

  function automatic logic [31:0] outVec();
    return {20'd0, x_load, sum_rst, mul_srdy_o, sum_en, coeff_sel,
            busy, srdyo, overrun_err, timeout_err};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses srdyi for one cycle. On return it is 1 ns into the LOAD cycle.
  task automatic applyStimulus(input logic [31:0] x, output int unsigned start);
    @(posedge clk);
    #1;
    x_in  = x;
    srdyi = 1'b1;
    start = cyc;
    @(posedge clk);
    #1;
    srdyi = 1'b0;
  endtask

  task automatic waitSrdyo(input int budget, output int unsigned at);
    at = 32'hFFFF_FFFF;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (srdyo === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    @(posedge clk);
    #1;
    clr_err_i = 1'b1;
    @(posedge clk);
    #1;
    clr_err_i = 1'b0;
  endtask

  int unsigned snap_mul, snap_sum, snap_busy, snap_srdyo, snap_coeff;

  task automatic takeSnap();
    snap_mul   = mul_cnt;
    snap_sum   = sum_cnt;
    snap_busy  = busy_cnt;
    snap_srdyo = srdyo_cnt;
    snap_coeff = coeff_q.size();
  endtask

  // Waits for srdyo, then checks latency, result, pulse counts and coefficient order.
  task automatic finishSample(input string tag, input int lat, input logic [31:0] x,
                              input int unsigned start);
    int unsigned at;
    int          steps_cyc;
    logic [31:0] res;
    logic [31:0] sel_obs;
    steps_cyc = (ORDER + 1) * (lat + 1);
    waitSrdyo(steps_cyc + 40, at);
    checkOutput({tag, "_srdyo_cycle"}, at - start, 2 + steps_cyc);
    idleCycles(2);
    res = (result_q.size() > 0) ? result_q[$] : 32'hDEAD_BEEF;
    checkOutput({tag, "_result"}, res, polyRef(x));
    checkOutput({tag, "_srdyo_count"}, srdyo_cnt - snap_srdyo, 1);
    checkOutput({tag, "_mul_count"}, mul_cnt - snap_mul, ORDER + 1);
    checkOutput({tag, "_sum_en_count"}, sum_cnt - snap_sum, ORDER + 1);
    checkOutput({tag, "_busy_cycles"}, busy_cnt - snap_busy, steps_cyc + 1);
    for (int k = 0; k <= ORDER; k++) begin
      sel_obs = (snap_coeff + k < coeff_q.size()) ? 32'(coeff_q[snap_coeff + k]) : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_coeff_step%0d", tag, k), sel_obs, ORDER - k);
    end
  endtask

  task automatic runSample(input string tag, input int lat, input logic [31:0] x);
    int unsigned start;
    resp_lat = lat;
    takeSnap();
    applyStimulus(x, start);
    finishSample(tag, lat, x, start);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned start, t1, t2, t3, t4, fell;
    logic [31:0] x;
    bit          found;

    GlobalReset = 1'b0;
    srdyi       = 1'b0;
    clr_err_i   = 1'b0;
    for (int i = 0; i <= ORDER; i++) coef[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", outVec(), 32'd0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_outputs", outVec(), 32'd0);

    // Single sample, L=3: srdyo 42 cycles after srdyi
    runSample("basic_L3", 3, $urandom);
    checkOutput("basic_errors", {overrun_err, timeout_err}, 2'b00);

    // Randomised latency and sample
    for (int r = 0; r < 3; r++) begin
      runSample($sformatf("rand%0d", r), $urandom_range(1, 6), $urandom);
    end

    // Back-to-back samples with srdyi held high, L=1
    resp_lat = 1;
    x = $urandom;
    @(posedge clk);
    #1;
    x_in  = x;
    srdyi = 1'b1;
    start = cyc;
    waitSrdyo(100, t1);
    checkOutput("b2b_first", t1 - start, 22);
    waitSrdyo(100, t2);
    checkOutput("b2b_period1", t2 - t1, 22);
    waitSrdyo(100, t3);
    checkOutput("b2b_period2", t3 - t2, 22);
    @(posedge clk);
    #1;
    srdyi = 1'b0;
    waitSrdyo(100, t4);
    checkOutput("b2b_period3", t4 - t3, 22);
    idleCycles(2);
    checkOutput("b2b_overrun", overrun_err, 1'b1);
    checkOutput("b2b_result", result_q[$], polyRef(x));
    checkOutput("b2b_result_prev", result_q[result_q.size() - 2], polyRef(x));
    pulseClear();
    @(negedge clk);
    checkOutput("b2b_clear", overrun_err, 1'b0);

    // srdyi pulsed during WAIT of step 5; the evaluation is unaffected
    resp_lat = 3;
    x = $urandom;
    takeSnap();
    applyStimulus(x, start);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mul_srdy_o && coeff_sel == 4'd5) found = 1'b1;
    end
    checkOutput("ovr_found_step5", found, 1'b1);
    @(posedge clk);
    #1;
    srdyi = 1'b1;
    @(posedge clk);
    #1;
    srdyi = 1'b0;
    @(negedge clk);
    checkOutput("ovr_set", {overrun_err, busy}, 2'b11);
    finishSample("ovr", 3, x, start);
    pulseClear();
    @(negedge clk);
    checkOutput("ovr_cleared", overrun_err, 1'b0);

    // clr_err_i together with srdyi-while-busy: the set wins
    x = $urandom;
    takeSnap();
    applyStimulus(x, start);
    @(posedge clk);
    #1;
    srdyi     = 1'b1;
    clr_err_i = 1'b1;
    @(posedge clk);
    #1;
    srdyi     = 1'b0;
    clr_err_i = 1'b0;
    @(negedge clk);
    checkOutput("set_wins", overrun_err, 1'b1);
    finishSample("setwins", 3, x, start);
    pulseClear();

    // Adder never responds: abort after 63 WAIT cycles
    resp_en = 1'b0;
    takeSnap();
    applyStimulus($urandom, start);
    fell = 32'hFFFF_FFFF;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        fell = cyc;
        break;
      end
    end
    checkOutput("timeout_idle_cycle", fell - start, 3 + TIMEOUT);
    checkOutput("timeout_flags", {timeout_err, overrun_err, srdyo}, 3'b100);
    idleCycles(3);
    checkOutput("timeout_no_srdyo", srdyo_cnt - snap_srdyo, 0);
    pulseClear();
    @(negedge clk);
    checkOutput("timeout_cleared", timeout_err, 1'b0);

    // add_done_i on the 63rd WAIT cycle is accepted
    resp_en = 1'b1;
    runSample("timeout_edge", TIMEOUT, $urandom);
    checkOutput("timeout_edge_flag", timeout_err, 1'b0);

    // Reset pulsed mid-evaluation at coeff_sel=4
    resp_lat = 3;
    takeSnap();
    applyStimulus($urandom, start);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (coeff_sel == 4'd4) found = 1'b1;
    end
    checkOutput("rst_found_sel4", found, 1'b1);
    #2;
    GlobalReset = 1'b0;
    #1;
    checkOutput("rst_async_outputs", outVec(), 32'd0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    idleCycles(10);
    checkOutput("rst_no_srdyo", srdyo_cnt - snap_srdyo, 0);
    runSample("after_reset", 3, $urandom);

    // add_done_i in IDLE is ignored
    takeSnap();
    @(posedge clk);
    #1;
    manual_pulse = 1'b1;
    @(negedge clk);
    checkOutput("idle_add_done_sum_en", sum_en, 1'b0);
    @(posedge clk);
    #1;
    manual_pulse = 1'b0;
    @(negedge clk);
    checkOutput("idle_add_done_state", outVec(), 32'd0);

    // add_done_i in ISSUE is ignored
    x = $urandom;
    takeSnap();
    applyStimulus(x, start);
    @(posedge clk);
    #1;
    manual_pulse = 1'b1;
    @(negedge clk);
    checkOutput("issue_add_done", {mul_srdy_o, sum_en}, 2'b10);
    @(posedge clk);
    #1;
    manual_pulse = 1'b0;
    finishSample("issue_stray", 3, x, start);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
